// File: rtl/guard_pkg.sv
// guard_pkg: shared state and op encodings for the guarded-evaluation adder controller.
package guard_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_BYP  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;
    localparam logic OP_BYP = 1'b0;
    localparam logic OP_ADD = 1'b1;
endpackage

// File: rtl/guard_ctrl_sat_counter.sv
// sat_counter: synchronous-clear up-counter that sticks at all-ones.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt
);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (i_clr)
            r_cnt <= '0;
        else if (i_en && r_cnt != '1)
            r_cnt <= r_cnt + CW'(1);
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/guard_ctrl.sv
// guard_ctrl: drives a guarded adder, raising its select only while an ADD evaluates,
// and returns results over valid/ready with gated-cycle and ADD counters.
module guard_ctrl import guard_pkg::*; #(
    parameter int W      = 32,
    parameter int SETTLE = 1,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_op,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [W-1:0]  in_bypass,
    output logic [W-1:0]  g_a,
    output logic [W-1:0]  g_b,
    output logic [W-1:0]  g_in,
    output logic          g_sel,
    input  logic [W-1:0]  g_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] gated_cnt,
    output logic [CW-1:0] add_cnt
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t        r_state, w_next;
    logic [SW-1:0] r_cnt;
    logic [W-1:0]  r_a, r_b, r_in, r_data;
    logic          r_sel, r_valid;
    logic [CW-1:0] r_add_cnt;
    logic          w_accept, w_eval_last, w_out_hs;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_accept ? ((in_op == OP_ADD) ? ST_EVAL : ST_BYP) : ST_IDLE;
            ST_EVAL: w_next = w_eval_last ? ST_OUT : ST_EVAL;
            ST_BYP:  w_next = ST_OUT;
            ST_OUT:  w_next = w_out_hs ? ST_IDLE : ST_OUT;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == ST_IDLE) && !rst;
        w_accept    = in_valid && in_ready;
        w_eval_last = (r_state == ST_EVAL) && (r_cnt == SW'(SETTLE - 1));
        w_out_hs    = (r_state == ST_OUT) && out_ready;
    end

    // Adder operands only move on their own op's accept so the adder's latches see no toggles otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_in      <= '0;
            r_sel     <= 1'b0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_add_cnt <= '0;
        end else begin
            if (w_accept && in_op == OP_ADD) begin
                r_a   <= in_a;
                r_b   <= in_b;
                r_sel <= 1'b1;
            end
            if (w_accept && in_op == OP_BYP)
                r_in <= in_bypass;
            r_cnt <= (r_state == ST_EVAL) ? r_cnt + SW'(1) : '0;
            if (w_eval_last) begin
                r_sel     <= 1'b0;
                r_add_cnt <= r_add_cnt + CW'(1);
            end
            if (w_eval_last || r_state == ST_BYP) begin
                r_data  <= g_y;
                r_valid <= 1'b1;
            end
            if (w_out_hs)
                r_valid <= 1'b0;
        end
    end

    sat_counter #(.CW(CW)) u_gated (
        .clk   (clk),
        .i_clr (rst),
        .i_en  (!r_sel),
        .o_cnt (gated_cnt)
    );

    assign g_a       = r_a;
    assign g_b       = r_b;
    assign g_in      = r_in;
    assign g_sel     = r_sel;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign add_cnt   = r_add_cnt;
endmodule

// File: tb/tb_guard_ctrl.sv
// tb_guard_ctrl: directed checks of guard_ctrl with a behavioural guarded adder on the g_* loop.
module tb_guard_ctrl;
    logic        clk = 1'b0, rst = 1'b1, in_op = 1'b0, out_ready = 1'b1;
    logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, in_bypass = '0;
    logic        rdy_a, gsel_a, ov_a, rdy_b, gsel_b, ov_b;
    logic [31:0] ga_a, gb_a, gin_a, gy_a, od_a, ga_b, gb_b, gin_b, gy_b, od_b;
    logic [3:0]  gc_a, ac_a;
    logic [15:0] gc_b, ac_b;
    int          n_pass = 0, n_chk = 0;

    always #5 clk = ~clk;

    // Guarded adder: sum while selected, bypass value otherwise; carry out is dropped.
    assign gy_a = gsel_a ? ga_a + gb_a : gin_a;
    assign gy_b = gsel_b ? ga_b + gb_b : gin_b;

    guard_ctrl #(.W(32), .SETTLE(1), .CW(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(rdy_a), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_bypass(in_bypass), .g_a(ga_a), .g_b(gb_a),
        .g_in(gin_a), .g_sel(gsel_a), .g_y(gy_a), .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .gated_cnt(gc_a), .add_cnt(ac_a)
    );

    guard_ctrl #(.W(32), .SETTLE(3), .CW(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(rdy_b), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_bypass(in_bypass), .g_a(ga_b), .g_b(gb_b),
        .g_in(gin_b), .g_sel(gsel_b), .g_y(gy_b), .out_valid(ov_b), .out_ready(out_ready),
        .out_data(od_b), .gated_cnt(gc_b), .add_cnt(ac_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rdy_in_rst", 32'(rdy_a), 0);
        rst = 1'b0;
        #1;
        check("rst_rdy", 32'(rdy_a), 1);
        check("rst_gsel", 32'(gsel_a), 0);
        check("rst_ov", 32'(ov_a), 0);
        check("rst_od", od_a, 0);
        check("rst_ga", ga_a, 0);
        check("rst_gc", 32'(gc_a), 0);
        check("rst_ac", 32'(ac_a), 0);
        repeat (20) tick();
        check("gc_sat", 32'(gc_a), 32'hF);
        check("gc_b_20", 32'(gc_b), 20);
        // ADD 5+7 with SETTLE=1
        in_valid_a = 1'b1; in_op = 1'b1; in_a = 5; in_b = 7;
        check("t1_rdy", 32'(rdy_a), 1);
        tick();
        in_valid_a = 1'b0;
        check("t1_sel1", 32'(gsel_a), 1);
        check("t1_ga", ga_a, 5);
        check("t1_rdy_eval", 32'(rdy_a), 0);
        check("t1_ov_c1", 32'(ov_a), 0);
        tick();
        check("t1_sel2", 32'(gsel_a), 0);
        check("t1_ov", 32'(ov_a), 1);
        check("t1_od", od_a, 12);
        check("t1_ac", 32'(ac_a), 1);
        check("t1_gc", 32'(gc_a), 32'hF);
        tick();
        check("t1_ov_done", 32'(ov_a), 0);
        check("t1_rdy_idle", 32'(rdy_a), 1);
        // ADD with wraparound on SETTLE=3 instance
        in_valid_b = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 2;
        tick();
        in_valid_b = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("t2_sel_c%0d", i), 32'(gsel_b), 1);
            check($sformatf("t2_ov_c%0d", i), 32'(ov_b), 0);
            tick();
        end
        check("t2_sel_c4", 32'(gsel_b), 0);
        check("t2_ov_c4", 32'(ov_b), 1);
        check("t2_od", od_b, 1);
        check("t2_ac", 32'(ac_b), 1);
        tick();
        // ADD 3+4 then BYPASS
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid_a = 1'b1; in_op = 1'b1; in_a = 3; in_b = 4;
        tick();
        in_valid_a = 1'b0;
        tick();
        check("t3_add_od", od_a, 7);
        check("t3_add_ac", 32'(ac_a), 1);
        tick();
        in_valid_a = 1'b1; in_op = 1'b0; in_bypass = 32'hDEAD_BEEF; in_a = 9; in_b = 9;
        tick();
        in_valid_a = 1'b0;
        check("t3_sel_c1", 32'(gsel_a), 0);
        check("t3_ov_c1", 32'(ov_a), 0);
        tick();
        check("t3_sel_c2", 32'(gsel_a), 0);
        check("t3_ov", 32'(ov_a), 1);
        check("t3_od", od_a, 32'hDEAD_BEEF);
        check("t3_ga", ga_a, 3);
        check("t3_gb", gb_a, 4);
        check("t3_gin", gin_a, 32'hDEAD_BEEF);
        check("t3_ac", 32'(ac_a), 1);
        tick();
        // Backpressure with in_valid held high
        out_ready = 1'b0;
        in_valid_a = 1'b1; in_op = 1'b1; in_a = 10; in_b = 20;
        tick();
        in_a = 100; in_b = 1;
        check("t4_sel", 32'(gsel_a), 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_ov_%0d", i), 32'(ov_a), 1);
            check($sformatf("t4_od_%0d", i), od_a, 30);
            check($sformatf("t4_rdy_%0d", i), 32'(rdy_a), 0);
            check($sformatf("t4_ga_%0d", i), ga_a, 10);
            tick();
        end
        out_ready = 1'b1;
        check("t4_ov_hold", 32'(ov_a), 1);
        tick();
        check("t4_ov_done", 32'(ov_a), 0);
        check("t4_rdy_idle", 32'(rdy_a), 1);
        check("t4_sel_idle", 32'(gsel_a), 0);
        tick();
        in_valid_a = 1'b0;
        check("t4_sel2", 32'(gsel_a), 1);
        check("t4_ga2", ga_a, 100);
        tick();
        check("t4_od2", od_a, 101);
        check("t4_ac", 32'(ac_a), 3);
        tick();
        // Reset during EVAL
        in_valid_a = 1'b1; in_op = 1'b1; in_a = 1; in_b = 1;
        tick();
        in_valid_a = 1'b0;
        check("t5_sel", 32'(gsel_a), 1);
        rst = 1'b1;
        tick();
        check("t5_sel_rst", 32'(gsel_a), 0);
        check("t5_ov_rst", 32'(ov_a), 0);
        check("t5_gc", 32'(gc_a), 0);
        check("t5_ac", 32'(ac_a), 0);
        rst = 1'b0;
        #1;
        check("t5_rdy", 32'(rdy_a), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_ov_%0d", i), 32'(ov_a), 0);
        end
        check("t5_gc3", 32'(gc_a), 3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
